// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: 4-byte register window, 8-entry byte FIFO and
// a start/data/stop shift FSM with a level interrupt on "idle and drained".
module uart_tx_port #(
    parameter logic [15:0] BASE_ADDR    = 16'hD000,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic        read_write,
    input  logic [7:0]  data_write,
    output logic [7:0]  data_read,
    output logic        selected,
    output logic        tx,
    output logic        irq
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_t;

    state_t      r_state, w_state_nx;
    logic [15:0] r_timer, w_timer_nx;
    logic [2:0]  r_idx, w_idx_nx;
    logic [7:0]  r_shift, w_shift_nx;
    logic        r_tx, w_tx_nx;

    logic [7:0]  r_mem [8];
    logic [2:0]  r_wptr, r_rptr;
    logic [3:0]  r_count, w_count_nx;
    logic        r_ovf;
    logic [1:0]  r_ctrl;
    logic        r_irq;

    logic        w_wr, w_push, w_push_ok, w_pop, w_can_pop;
    logic        w_empty, w_full, w_busy;

    assign selected  = (address[15:2] == BASE_ADDR[15:2]);
    assign w_wr      = selected & ~read_write;
    assign w_push    = w_wr & (address[1:0] == 2'd0);
    assign w_empty   = (r_count == 4'd0);
    assign w_full    = (r_count == 4'd8);
    assign w_push_ok = w_push & ~w_full;
    assign w_busy    = (r_state != StIdle);
    assign w_can_pop = r_ctrl[0] & ~w_empty;

    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_pop      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_can_pop) begin
                    w_pop      = 1'b1;
                    w_shift_nx = r_mem[r_rptr];
                    w_timer_nx = BIT_LAST;
                    w_state_nx = StStart;
                end
            end
            StStart: begin
                if (r_timer == 16'd0) begin
                    w_timer_nx = BIT_LAST;
                    w_idx_nx   = 3'd0;
                    w_state_nx = StData;
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end
            StData: begin
                if (r_timer == 16'd0) begin
                    w_timer_nx = BIT_LAST;
                    if (r_idx == 3'd7) begin
                        w_state_nx = StStop;
                    end else begin
                        w_shift_nx = {1'b0, r_shift[7:1]};
                        w_idx_nx   = r_idx + 3'd1;
                    end
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end
            StStop: begin
                if (r_timer == 16'd0) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (w_can_pop) begin
                        w_pop      = 1'b1;
                        w_shift_nx = r_mem[r_rptr];
                        w_timer_nx = BIT_LAST;
                        w_state_nx = StStart;
                    end else begin
                        w_state_nx = StIdle;
                    end
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end
            default: w_state_nx = StIdle;
        endcase

        unique case (w_state_nx)
            StStart: w_tx_nx = 1'b0;
            StData:  w_tx_nx = w_shift_nx[0];
            default: w_tx_nx = 1'b1;
        endcase
    end

    always_comb begin
        w_count_nx = r_count;
        unique case ({w_push_ok, w_pop})
            2'b10:   w_count_nx = r_count + 4'd1;
            2'b01:   w_count_nx = r_count - 4'd1;
            default: w_count_nx = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_timer <= 16'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
            r_wptr  <= 3'd0;
            r_rptr  <= 3'd0;
            r_count <= 4'd0;
            r_ovf   <= 1'b0;
            r_ctrl  <= 2'b01;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_tx    <= w_tx_nx;
            r_count <= w_count_nx;
            if (w_push_ok) r_wptr <= r_wptr + 3'd1;
            if (w_pop)     r_rptr <= r_rptr + 3'd1;
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr && address[1:0] == 2'd1 && data_write[7]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && address[1:0] == 2'd2) r_ctrl <= data_write[1:0];
            r_irq <= r_ctrl[1] & w_empty & ~w_busy;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= data_write;
    end

    always_comb begin
        data_read = 8'h00;
        if (selected) begin
            unique case (address[1:0])
                2'd1:    data_read = {r_ovf, r_count, w_busy, w_full, w_empty};
                2'd2:    data_read = {6'b0, r_ctrl};
                default: data_read = 8'h00;
            endcase
        end
    end

    assign tx  = r_tx;
    assign irq = r_irq;

endmodule
